// File: rtl/bcd_bin_converter.sv
// Iterative binary <-> packed-BCD converter: double dabble for bin->bcd and
// reverse double dabble for bcd->bin, one iteration per enabled clock edge.
module bcd_bin_converter #(
  parameter int W  = 16,
  parameter int ND = 5
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            CE,
  input  logic            START,
  input  logic            DIR,
  input  logic [W-1:0]    DIN,
  output logic            BUSY,
  output logic            DONE,
  output logic [4*ND-1:0] DOUT,
  output logic            ERR,
  output logic [1:0]      STATE
);

  localparam int DW = 4 * ND;
  localparam int WR = DW + W;
  localparam int NI = W / 4;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_FIN   = 2'd2
  } state_e;

  // Handshake: START is taken on a CE edge in IDLE or FIN; the result is valid
  // (DONE=1) for the whole FIN interval and DOUT/ERR hold until the next accept.
  state_e         state_q, state_d;
  logic [WR-1:0]  work_q, work_d;
  logic           dir_q, dir_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]  dout_q, dout_d;
  logic           err_q, err_d;

  logic           accept;
  logic           din_bad;
  logic           last_iter;
  logic [WR-1:0]  step_dab;
  logic [WR-1:0]  step_rev;
  logic [WR-1:0]  step_next;

  assign accept    = CE && START && (state_q != S_SHIFT);
  assign last_iter = (cnt_q == CW'(1));

  always_comb begin
    din_bad = 1'b0;
    for (int i = 0; i < NI; i++) begin
      if (DIN[4*i +: 4] > 4'd9) din_bad = 1'b1;
    end
  end

  // bin->bcd iteration: correct every BCD nibble >=5, then shift left.
  always_comb begin
    step_dab = work_q;
    for (int i = 0; i < ND; i++) begin
      if (step_dab[W+4*i +: 4] >= 4'd5)
        step_dab[W+4*i +: 4] = step_dab[W+4*i +: 4] + 4'd3;
    end
    step_dab = step_dab << 1;
  end

  // bcd->bin iteration: shift right, then correct every BCD nibble >=8.
  always_comb begin
    step_rev = work_q >> 1;
    for (int i = 0; i < NI; i++) begin
      if (step_rev[W+4*i +: 4] >= 4'd8)
        step_rev[W+4*i +: 4] = step_rev[W+4*i +: 4] - 4'd3;
    end
  end

  assign step_next = dir_q ? step_rev : step_dab;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      dout_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = (DIR && din_bad) ? S_FIN : S_SHIFT;
      end
      S_SHIFT: begin
        if (CE && last_iter) state_d = S_FIN;
      end
      S_FIN: begin
        if (accept)  state_d = (DIR && din_bad) ? S_FIN : S_SHIFT;
        else if (CE) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next-state: load on accept, iterate in SHIFT, otherwise hold.
  always_comb begin
    work_d = work_q;
    dir_d  = dir_q;
    cnt_d  = cnt_q;
    dout_d = dout_q;
    err_d  = err_q;
    if (accept) begin
      dir_d  = DIR;
      cnt_d  = CW'(W);
      err_d  = DIR && din_bad;
      dout_d = '0;
      work_d = DIR ? WR'({DIN, {W{1'b0}}}) : WR'(DIN);
    end else if (CE && (state_q == S_SHIFT)) begin
      work_d = step_next;
      cnt_d  = cnt_q - CW'(1);
      if (last_iter)
        dout_d = dir_q ? DW'(step_next[W-1:0]) : step_next[WR-1:W];
    end
  end

  always_comb begin
    BUSY  = (state_q == S_SHIFT);
    DONE  = (state_q == S_FIN);
    DOUT  = dout_q;
    ERR   = err_q;
    STATE = state_q;
  end

endmodule

// File: tb/tb_bcd_bin_converter.sv
// Directed bench for bcd_bin_converter (W=16, ND=5): vector table plus
// hand-written sequences for back-to-back, CE gating and mid-run reset.
module tb_bcd_bin_converter;

  logic        CLK;
  logic        RST_N;
  logic        CE;
  logic        START;
  logic        DIR;
  logic [15:0] DIN;
  logic        BUSY;
  logic        DONE;
  logic [19:0] DOUT;
  logic        ERR;
  logic [1:0]  STATE;

  int checks = 0;
  int errors = 0;
  logic [19:0] exp_q[$];

  typedef struct {
    logic        dir;
    logic [15:0] din;
    logic [19:0] dout;
    logic        err;
  } vec_t;

  vec_t vecs[13];

  bcd_bin_converter #(.W(16), .ND(5)) dut (
    .CLK(CLK), .RST_N(RST_N), .CE(CE), .START(START), .DIR(DIR), .DIN(DIN),
    .BUSY(BUSY), .DONE(DONE), .DOUT(DOUT), .ERR(ERR), .STATE(STATE)
  );

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Issue one conversion with CE held high and wait for DONE.
  task automatic run_conv(input logic dir, input logic [15:0] din,
                          input logic [19:0] exp_dout, input logic exp_err);
    int edges;
    int busy_cnt;
    logic [19:0] exp;
    exp_q.push_back(exp_dout);
    CE = 1'b1; START = 1'b1; DIR = dir; DIN = din;
    cyc();
    START = 1'b0;
    DIN = 16'($urandom_range(0, 65535));
    DIR = 1'($urandom_range(0, 1));
    edges = 1;
    busy_cnt = 0;
    while (!DONE && edges < 40) begin
      if (BUSY) busy_cnt++;
      cyc();
      edges++;
    end
    exp = exp_q.pop_front();
    check("done_seen", 32'(DONE), 32'd1);
    check("latency", 32'(edges), exp_err ? 32'd1 : 32'd17);
    check("busy_cycles", 32'(busy_cnt), exp_err ? 32'd0 : 32'd16);
    check("busy_at_done", 32'(BUSY), 32'd0);
    check("dout", 32'(DOUT), 32'(exp));
    check("err", 32'(ERR), 32'(exp_err));
    cyc();
    check("done_drop", 32'(DONE), 32'd0);
    check("dout_hold", 32'(DOUT), 32'(exp));
    check("err_hold", 32'(ERR), 32'(exp_err));
  endtask

  initial begin
    int ce_edges;
    int n;

    vecs[0]  = '{1'b0, 16'hFFFF, 20'h65535, 1'b0};
    vecs[1]  = '{1'b0, 16'h0000, 20'h00000, 1'b0};
    vecs[2]  = '{1'b0, 16'h270F, 20'h09999, 1'b0};
    vecs[3]  = '{1'b0, 16'h3039, 20'h12345, 1'b0};
    vecs[4]  = '{1'b0, 16'h0001, 20'h00001, 1'b0};
    vecs[5]  = '{1'b0, 16'h8000, 20'h32768, 1'b0};
    vecs[6]  = '{1'b1, 16'h9999, 20'h0270F, 1'b0};
    vecs[7]  = '{1'b1, 16'h1234, 20'h004D2, 1'b0};
    vecs[8]  = '{1'b1, 16'h0000, 20'h00000, 1'b0};
    vecs[9]  = '{1'b1, 16'h0100, 20'h00064, 1'b0};
    vecs[10] = '{1'b1, 16'h12A4, 20'h00000, 1'b1};
    vecs[11] = '{1'b1, 16'hF000, 20'h00000, 1'b1};
    vecs[12] = '{1'b1, 16'h0009, 20'h00009, 1'b0};

    RST_N = 1'b0; CE = 1'b0; START = 1'b0; DIR = 1'b0; DIN = '0;
    cyc();
    cyc();
    RST_N = 1'b1;
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    check("rst_dout", 32'(DOUT), 32'd0);
    check("rst_err", 32'(ERR), 32'd0);

    foreach (vecs[i]) run_conv(vecs[i].dir, vecs[i].din, vecs[i].dout, vecs[i].err);

    // back-to-back: START held while in FIN, no idle cycle in between
    CE = 1'b1; START = 1'b1; DIR = 1'b0; DIN = 16'h0000;
    cyc();
    START = 1'b0;
    n = 0;
    while (!DONE && n < 40) begin cyc(); n++; end
    check("b2b_first_dout", 32'(DOUT), 32'h00000);
    START = 1'b1; DIN = 16'h270F;
    cyc();
    START = 1'b0;
    check("b2b_busy", 32'(BUSY), 32'd1);
    check("b2b_done_low", 32'(DONE), 32'd0);
    n = 1;
    while (!DONE && n < 40) begin cyc(); n++; end
    check("b2b_latency", 32'(n), 32'd17);
    check("b2b_second_dout", 32'(DOUT), 32'h09999);
    cyc();

    // CE toggling, second START and DIN changes during SHIFT ignored
    CE = 1'b1; START = 1'b1; DIR = 1'b0; DIN = 16'h0400;
    cyc();
    ce_edges = 1;
    n = 0;
    while (!DONE && n < 100) begin
      CE = ~CE;
      START = CE && (ce_edges == 5);
      DIR = 1'b1;
      DIN = 16'hFFFF;
      cyc();
      if (CE) ce_edges++;
      n++;
    end
    START = 1'b0;
    check("ce_latency", 32'(ce_edges), 32'd17);
    check("ce_dout", 32'(DOUT), 32'h01024);
    check("ce_err", 32'(ERR), 32'd0);
    CE = 1'b0;
    cyc();
    check("ce_done_frozen", 32'(DONE), 32'd1);
    CE = 1'b1;
    cyc();
    check("ce_done_drop", 32'(DONE), 32'd0);

    // error result first so the reset has ERR to clear, then abort mid-run
    run_conv(1'b1, 16'hA000, 20'h00000, 1'b1);
    CE = 1'b1; START = 1'b1; DIR = 1'b0; DIN = 16'hFFFF;
    cyc();
    START = 1'b0;
    for (int k = 0; k < 4; k++) cyc();
    RST_N = 1'b0; CE = 1'b0;
    cyc();
    RST_N = 1'b1; CE = 1'b1;
    check("abort_busy", 32'(BUSY), 32'd0);
    check("abort_done", 32'(DONE), 32'd0);
    check("abort_dout", 32'(DOUT), 32'd0);
    check("abort_err", 32'(ERR), 32'd0);
    check("abort_state", 32'(STATE), 32'd0);
    run_conv(1'b0, 16'h0064, 20'h00100, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
